// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline MEM stage.
// Contents:
//   RNW          - register-number width (destination register field)
//   mem_state_e  - MEM-stage controller FSM encoding (idle / waiting for ack / done)
package pipe_pkg;

   localparam int RNW = 5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } mem_state_e;

endpackage

// File: rtl/pipemwreg.sv
// MEM/WB pipeline register.
// Ports:
//   clock      - rising-edge clock
//   resetn     - synchronous active-low reset, clears every field
//   bubble_i   - load an all-zero bubble instead of the inputs
//   wreg_i, m2reg_i, mo_i, alu_i, rn_i  - next MEM/WB contents
//   wreg_o, m2reg_o, mo_o, alu_o, rn_o  - registered MEM/WB contents
module pipemwreg
   import pipe_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic           clock,
   input  logic           resetn,
   input  logic           bubble_i,
   input  logic           wreg_i,
   input  logic           m2reg_i,
   input  logic [DW-1:0]  mo_i,
   input  logic [DW-1:0]  alu_i,
   input  logic [RNW-1:0] rn_i,
   output logic           wreg_o,
   output logic           m2reg_o,
   output logic [DW-1:0]  mo_o,
   output logic [DW-1:0]  alu_o,
   output logic [RNW-1:0] rn_o
);

   logic           wreg_q;
   logic           m2reg_q;
   logic [DW-1:0]  mo_q;
   logic [DW-1:0]  alu_q;
   logic [RNW-1:0] rn_q;

   always_ff @(posedge clock) begin
      if (!resetn || bubble_i) begin
         wreg_q  <= 1'b0;
         m2reg_q <= 1'b0;
         mo_q    <= '0;
         alu_q   <= '0;
         rn_q    <= '0;
      end else begin
         wreg_q  <= wreg_i;
         m2reg_q <= m2reg_i;
         mo_q    <= mo_i;
         alu_q   <= alu_i;
         rn_q    <= rn_i;
      end
   end

   assign wreg_o  = wreg_q;
   assign m2reg_o = m2reg_q;
   assign mo_o    = mo_q;
   assign alu_o   = alu_q;
   assign rn_o    = rn_q;

endmodule

// File: rtl/pipemem_ctl.sv
// MEM-stage controller: drives a variable-latency data memory over a
// req/ack handshake, stalls the upstream pipeline while an access is
// outstanding, and owns the MEM/WB register.
// Ports:
//   clock, resetn                      - clock, synchronous active-low reset
//   mwreg, mm2reg, mwmem, malu, mb, mrn - EX/MEM register outputs
//   mem_req, mem_we, mem_addr, mem_wdata - memory request (held until ack)
//   mem_ack, mem_rdata                 - memory completion / read data
//   stall                              - freeze PC and upstream pipeline registers
//   wwreg, wm2reg, wmo, walu, wrn      - MEM/WB register outputs
module pipemem_ctl
   import pipe_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic           clock,
   input  logic           resetn,
   input  logic           mwreg,
   input  logic           mm2reg,
   input  logic           mwmem,
   input  logic [AW-1:0]  malu,
   input  logic [DW-1:0]  mb,
   input  logic [RNW-1:0] mrn,
   output logic           mem_req,
   output logic           mem_we,
   output logic [AW-1:0]  mem_addr,
   output logic [DW-1:0]  mem_wdata,
   input  logic           mem_ack,
   input  logic [DW-1:0]  mem_rdata,
   output logic           stall,
   output logic           wwreg,
   output logic           wm2reg,
   output logic [DW-1:0]  wmo,
   output logic [DW-1:0]  walu,
   output logic [RNW-1:0] wrn
);

   mem_state_e    state_q, state_d;
   logic [DW-1:0] rbuf_q;
   logic          access;
   logic          capture;
   logic          bubble;
   logic [DW-1:0] mo_d;
   logic [DW-1:0] alu_ext;

   assign access = mm2reg | mwmem;

   // ALU result is carried at data width into write-back.
   generate
      if (AW >= DW) begin : g_alu_trunc
         assign alu_ext = malu[DW-1:0];
      end else begin : g_alu_zext
         assign alu_ext = {{(DW-AW){1'b0}}, malu};
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         rbuf_q  <= '0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            rbuf_q <= mem_rdata;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      mem_req = 1'b0;
      stall   = 1'b0;
      bubble  = 1'b0;
      capture = 1'b0;
      mo_d    = '0;
      // Reset forces the request and stall low in the reset cycle itself,
      // regardless of which state the register still holds.
      if (resetn) begin
         unique case (state_q)
            S_IDLE, S_WAIT: begin
               // WAIT is only ever entered with an access pending; EX/MEM is
               // frozen, so re-evaluating access here keeps the request held.
               if (access || state_q == S_WAIT) begin
                  mem_req = 1'b1;
                  stall   = 1'b1;
                  bubble  = 1'b1;
                  capture = mem_ack & mm2reg;
                  state_d = mem_ack ? S_DONE : S_WAIT;
               end
            end
            S_DONE: begin
               mo_d    = mm2reg ? rbuf_q : '0;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign mem_we    = mem_req & mwmem;
   assign mem_addr  = mem_req ? {malu[AW-1:2], 2'b00} : '0;
   assign mem_wdata = mem_req ? mb : '0;

   pipemwreg #(.DW(DW)) u_mwreg (
      .clock    (clock),
      .resetn   (resetn),
      .bubble_i (bubble),
      .wreg_i   (mwreg),
      .m2reg_i  (mm2reg),
      .mo_i     (mo_d),
      .alu_i    (alu_ext),
      .rn_i     (mrn),
      .wreg_o   (wwreg),
      .m2reg_o  (wm2reg),
      .mo_o     (wmo),
      .alu_o    (walu),
      .rn_o     (wrn)
   );

endmodule

// File: doc/pipemem_ctl.md
# pipemem_ctl

MEM-stage controller of the 5-stage pipeline: the consumer of the EX/MEM register outputs (mwreg, mm2reg, mwmem, malu, mb, mrn). It drives a variable-latency data memory over a req/ack handshake, freezes the upstream pipeline while an access is outstanding, and owns the MEM/WB register feeding the write-back stage.

## Interface
Parameters:
- AW, 32, byte-address width (malu, mem_addr)
- DW, 32, data width (mb, mem_rdata, wmo, walu)

Ports (one clock; reset is synchronous and active-low):
- clock  in  1  rising-edge clock
- resetn  in  1  synchronous active-low reset
- mwreg  in  1  instruction writes register file
- mm2reg  in  1  load (result from memory)
- mwmem  in  1  store
- malu  in  AW  ALU result / effective address
- mb  in  DW  store data
- mrn  in  5  destination register
- mem_req  out  1  memory request, held until accepted
- mem_we  out  1  1 = write, 0 = read; valid with mem_req
- mem_addr  out  AW  {malu[AW-1:2],2'b00}
- mem_wdata  out  DW  mb
- mem_ack  in  1  memory completes request this cycle
- mem_rdata  in  DW  read data, valid with mem_ack on read
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
- wwreg, wm2reg  out  1 each  MEM/WB registered controls
- wmo  out  DW  registered load data
- walu  out  DW  registered ALU result
- wrn  out  5  registered destination

## Operation
- access = mm2reg | mwmem (mutually exclusive by decode).
- FSM states IDLE, WAIT, DONE; reset state IDLE.
- IDLE, no access: stall=0, mem_req=0; MEM/WB loads {mwreg, mm2reg, 0, malu, mrn}.
- IDLE, access: mem_req=1, mem_we=mwmem, stall=1; MEM/WB loads bubble (wwreg=0, wm2reg=0, wmo=0, walu=0, wrn=0). mem_ack at edge -> DONE (capture mem_rdata into rbuf if load), else -> WAIT.
- WAIT: mem_req=1, same addr/we/wdata (EX/MEM frozen), stall=1, MEM/WB loads bubble; mem_ack -> DONE with capture, else stay.
- DONE: mem_req=0, stall=0; MEM/WB loads {mwreg, mm2reg, load ? rbuf : 0, malu, mrn}; -> IDLE unconditionally (next instruction enters at this edge).
- mem_ack while mem_req=0 is ignored; rbuf unchanged.
- mem_req, mem_we, mem_addr, mem_wdata, stall are combinational from state + EX/MEM inputs; mem_we/addr/wdata are 0 when mem_req=0.
- Reset (resetn=0 at edge), any state: -> IDLE, rbuf=0, all MEM/WB outputs 0; outstanding request dropped, memory must tolerate req deassertion.

## Timing
- Non-memory instruction: 1 cycle in MEM, no stall.
- Memory instruction: 2 + N cycles in MEM where N = cycles mem_req held before mem_ack (ack in first request cycle -> 1 stall cycle).
- Load data visible on wmo the edge after the DONE cycle, aligned with wm2reg=1.
- Back-to-back memory ops: DONE -> IDLE -> new request next cycle; no idle gap beyond DONE.
- Outputs during reset cycle: mem_req=0, stall=0; registered outputs 0 after the edge.

## Structure
- Shared package pipe_pkg: FSM state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2), register-number width 5.
- Sub-module pipemwreg: MEM/WB register with bubble input, synchronous active-low reset; controller instantiates it.

## Test plan
- ALU op (mwreg=1, malu=0x0000_0010, mrn=5): no stall, next edge wwreg=1, walu=0x10, wrn=5, wmo=0, mem_req never 1.
- Load, ack in first cycle (malu=0x100, mem_rdata=0xDEAD_BEEF): mem_req=1, mem_we=0, mem_addr=0x100, stall=1 one cycle; after DONE wm2reg=1, wmo=0xDEADBEEF, wrn=mrn.
- Store, ack after 3 wait cycles (malu=0x203, mb=0x1234): mem_addr=0x200, mem_we=1, mem_wdata=0x1234 stable 4 cycles, stall=1 4 cycles, bubbles (wwreg=0) on MEM/WB during stall.
- Spurious mem_ack=1 with mem_rdata=0xFFFF_FFFF during ALU ops: no state change, wmo stays 0.
- resetn=0 in WAIT: next edge state IDLE, mem_req=0, stall=0, all w* outputs 0; following load starts fresh request.
- Back-to-back loads 0x40, 0x44 with 1-cycle ack: each 2 MEM cycles, wmo sequence correct, no lost/duplicated writeback.
